// File: rtl/cpu_control_unit.sv
// Multi-cycle Hack-style instruction sequencer: fetches instructions, holds A/D/PC,
// drives an external combinational ALU and performs writeback and jump resolution.
module cpu_control_unit #(
    parameter int unsigned         PC_WIDTH = 15,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         instr_in,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [15:0]         mem_in,
    output logic [PC_WIDTH-1:0] mem_addr,
    output logic [15:0]         mem_out,
    output logic                mem_write,
    output logic [PC_WIDTH-1:0] pc,
    output logic [15:0]         alu_x,
    output logic [15:0]         alu_y,
    output logic [5:0]          alu_ctrl,
    input  logic [15:0]         alu_out,
    input  logic                alu_zr,
    input  logic                alu_ng
);

    typedef enum logic [1:0] {
        FETCH,
        WB_A,
        EXEC,
        WB_C
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t              state;
    logic [15:0]         a_reg;
    logic [15:0]         d_reg;
    logic [14:0]         ir;
    logic [15:0]         res;
    logic                zr_q;
    logic                ng_q;
    logic                mem_write_q;
    logic [PC_WIDTH-1:0] pc_reg;
    logic                jump;

    always_comb begin
        jump = (ir[2] & ng_q) | (ir[1] & zr_q) | (ir[0] & ~ng_q & ~zr_q);
    end

    // The write strobe is set on the EXEC edge so it is high throughout WB_C,
    // while A still holds the pre-writeback address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            a_reg       <= '0;
            d_reg       <= '0;
            pc_reg      <= RESET_PC;
            ir          <= '0;
            res         <= '0;
            zr_q        <= 1'b0;
            ng_q        <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            mem_write_q <= 1'b0;
            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        ir    <= instr_in[14:0];
                        state <= instr_in[15] ? EXEC : WB_A;
                    end
                end
                WB_A: begin
                    a_reg  <= {1'b0, ir};
                    pc_reg <= pc_reg + PC_ONE;
                    state  <= FETCH;
                end
                EXEC: begin
                    res         <= alu_out;
                    zr_q        <= alu_zr;
                    ng_q        <= alu_ng;
                    mem_write_q <= ir[3];
                    state       <= WB_C;
                end
                WB_C: begin
                    if (ir[5]) a_reg <= res;
                    if (ir[4]) d_reg <= res;
                    pc_reg <= jump ? a_reg[PC_WIDTH-1:0] : pc_reg + PC_ONE;
                    state  <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        instr_ready = (state == FETCH);
        mem_addr    = a_reg[PC_WIDTH-1:0];
        mem_out     = res;
        mem_write   = mem_write_q;
        pc          = pc_reg;
        alu_x       = d_reg;
        alu_y       = ir[12] ? mem_in : a_reg;
        alu_ctrl    = ir[11:6];
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed vector table, corner-case
// sequences and random instructions checked against a Hack-machine reference model.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] mem_in;
    logic [14:0] mem_addr;
    logic [15:0] mem_out;
    logic        mem_write;
    logic [14:0] pc;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_ctrl;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_control_unit #(.PC_WIDTH(15), .RESET_PC(15'h0000)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .mem_in(mem_in), .mem_addr(mem_addr),
        .mem_out(mem_out), .mem_write(mem_write), .pc(pc), .alu_x(alu_x),
        .alu_y(alu_y), .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_zr(alu_zr),
        .alu_ng(alu_ng)
    );

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    function automatic logic [15:0] init_word(input logic [14:0] a);
        logic [15:0] t;
        t = {1'b0, a};
        return (t * 16'h9E37) ^ 16'h5A5A;
    endfunction

    assign alu_out = hack_alu(alu_x, alu_y, alu_ctrl);
    assign alu_zr  = (alu_out == 16'h0000);
    assign alu_ng  = alu_out[15];

    // Data memory seen by the DUT: unwritten words read a fixed address-derived pattern.
    logic [15:0]    tb_mem [0:32767];
    logic [32767:0] written;
    logic           mem_clr;
    assign mem_in = written[mem_addr] ? tb_mem[mem_addr] : init_word(mem_addr);

    always @(posedge clk) begin
        if (mem_clr) written <= '0;
        else if (mem_write) begin
            written[mem_addr] <= 1'b1;
            tb_mem[mem_addr]  <= mem_out;
        end
    end

    // Reference Hack machine state
    logic [15:0] ref_mem [0:32767];
    logic [15:0] m_a, m_d;
    logic [14:0] m_pc;
    int          last_nw;
    logic [14:0] last_waddr;
    logic [15:0] last_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_a  = 16'h0000;
        m_d  = 16'h0000;
        m_pc = 15'h0000;
    endtask

    // Starts and ends on a negedge with the DUT in FETCH.
    task automatic run_instr(input logic [15:0] ins);
        logic [15:0] y_exp, r, a_old, wdata;
        logic        zr, ng, jmp, exp_w;
        logic [14:0] exp_waddr, waddr;
        logic [15:0] exp_wdata;
        logic [5:0]  ctrl_seen;
        logic [15:0] y_seen;
        int          cyc, nw;

        exp_w = 1'b0; exp_waddr = '0; exp_wdata = '0; y_exp = '0;
        ctrl_seen = '0; y_seen = '0; waddr = '0; wdata = '0;
        if (!ins[15]) begin
            m_a  = ins;
            m_pc = m_pc + 15'd1;
        end else begin
            a_old = m_a;
            y_exp = ins[12] ? ref_mem[m_a[14:0]] : m_a;
            r     = hack_alu(m_d, y_exp, ins[11:6]);
            zr    = (r == 16'h0000);
            ng    = r[15];
            if (ins[3]) begin
                exp_w     = 1'b1;
                exp_waddr = a_old[14:0];
                exp_wdata = r;
                ref_mem[a_old[14:0]] = r;
            end
            if (ins[5]) m_a = r;
            if (ins[4]) m_d = r;
            jmp  = (ins[2] & ng) | (ins[1] & zr) | (ins[0] & ~ng & ~zr);
            m_pc = jmp ? a_old[14:0] : m_pc + 15'd1;
        end

        chk("ready_before", instr_ready, 1);
        instr_in    = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr_in    = 16'($urandom);
        cyc = 1;
        nw  = 0;
        while (!instr_ready && cyc < 8) begin
            if (mem_write) begin
                nw++;
                waddr = mem_addr;
                wdata = mem_out;
            end
            if (cyc == 1) begin
                ctrl_seen = alu_ctrl;
                y_seen    = alu_y;
            end
            @(negedge clk);
            cyc++;
        end
        if (mem_write) nw++;

        chk("latency", cyc, ins[15] ? 3 : 2);
        chk("pc", pc, m_pc);
        chk("a_reg", mem_addr, m_a[14:0]);
        chk("d_reg", alu_x, m_d);
        chk("write_count", nw, exp_w);
        if (ins[15]) begin
            chk("alu_ctrl_exec", ctrl_seen, ins[11:6]);
            chk("alu_y_exec", y_seen, y_exp);
        end
        if (exp_w) begin
            chk("write_addr", waddr, exp_waddr);
            chk("write_data", wdata, exp_wdata);
        end
        last_nw    = nw;
        last_waddr = waddr;
        last_wdata = wdata;
    endtask

    typedef struct {
        logic [15:0] ins;
        logic [14:0] pc;
        logic [15:0] a;
        logic [15:0] d;
        logic        wr;
        logic [14:0] waddr;
        logic [15:0] wdata;
    } vec_t;

    vec_t vt [18];

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{16'h1234, 15'h0001, 16'h1234, 16'h0000, 1'b0, 15'h0000, 16'h0000};
        vt[1]  = '{16'h0005, 15'h0002, 16'h0005, 16'h0000, 1'b0, 15'h0000, 16'h0000};
        vt[2]  = '{16'hEC10, 15'h0003, 16'h0005, 16'h0005, 1'b0, 15'h0000, 16'h0000};
        vt[3]  = '{16'h0003, 15'h0004, 16'h0003, 16'h0005, 1'b0, 15'h0000, 16'h0000};
        vt[4]  = '{16'hE090, 15'h0005, 16'h0003, 16'h0008, 1'b0, 15'h0000, 16'h0000};
        vt[5]  = '{16'h0010, 15'h0006, 16'h0010, 16'h0008, 1'b0, 15'h0000, 16'h0000};
        vt[6]  = '{16'hE308, 15'h0007, 16'h0010, 16'h0008, 1'b1, 15'h0010, 16'h0008};
        vt[7]  = '{16'h0040, 15'h0008, 16'h0040, 16'h0008, 1'b0, 15'h0000, 16'h0000};
        vt[8]  = '{16'hE301, 15'h0040, 16'h0040, 16'h0008, 1'b0, 15'h0000, 16'h0000};
        vt[9]  = '{16'h0008, 15'h0041, 16'h0008, 16'h0008, 1'b0, 15'h0000, 16'h0000};
        vt[10] = '{16'hECD0, 15'h0042, 16'h0008, 16'hFFF8, 1'b0, 15'h0000, 16'h0000};
        vt[11] = '{16'h0040, 15'h0043, 16'h0040, 16'hFFF8, 1'b0, 15'h0000, 16'h0000};
        vt[12] = '{16'hE301, 15'h0044, 16'h0040, 16'hFFF8, 1'b0, 15'h0000, 16'h0000};
        vt[13] = '{16'h0050, 15'h0045, 16'h0050, 16'hFFF8, 1'b0, 15'h0000, 16'h0000};
        vt[14] = '{16'hE327, 15'h0050, 16'hFFF8, 16'hFFF8, 1'b0, 15'h0000, 16'h0000};
        vt[15] = '{16'h7FFF, 15'h0051, 16'h7FFF, 16'hFFF8, 1'b0, 15'h0000, 16'h0000};
        vt[16] = '{16'hEA87, 15'h7FFF, 16'h7FFF, 16'hFFF8, 1'b0, 15'h0000, 16'h0000};
        vt[17] = '{16'h0001, 15'h0000, 16'h0001, 16'hFFF8, 1'b0, 15'h0000, 16'h0000};

        for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(15'(i));
        model_reset();
        reset       = 1'b1;
        mem_clr     = 1'b1;
        instr_valid = 1'b0;
        instr_in    = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_ready", instr_ready, 1);
        chk("rst_pc", pc, 15'h0000);
        chk("rst_a", mem_addr, 15'h0000);
        chk("rst_d", alu_x, 16'h0000);
        chk("rst_alu_ctrl", alu_ctrl, 6'b000000);
        chk("rst_mem_write", mem_write, 0);
        reset   = 1'b0;
        mem_clr = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_instr(vt[i].ins);
            chk("tbl_pc", pc, vt[i].pc);
            chk("tbl_a", mem_addr, vt[i].a[14:0]);
            chk("tbl_d", alu_x, vt[i].d);
            chk("tbl_write", last_nw, vt[i].wr);
            if (vt[i].wr) begin
                chk("tbl_waddr", last_waddr, vt[i].waddr);
                chk("tbl_wdata", last_wdata, vt[i].wdata);
            end
        end

        // Idle with instr_valid low: nothing may change.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ready", instr_ready, 1);
            chk("idle_pc", pc, m_pc);
            chk("idle_a", mem_addr, m_a[14:0]);
            chk("idle_d", alu_x, m_d);
            chk("idle_write", mem_write, 0);
        end

        // instr_valid held through WB_A with a different word must be ignored.
        instr_in    = 16'h0123;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_in = 16'h0456;
        chk("busy_ready", instr_ready, 0);
        @(negedge clk);
        instr_valid = 1'b0;
        m_a  = 16'h0123;
        m_pc = m_pc + 15'd1;
        chk("busy_ready_back", instr_ready, 1);
        chk("busy_a", mem_addr, 15'h0123);
        chk("busy_pc", pc, m_pc);
        @(negedge clk);
        chk("busy_still_fetch", instr_ready, 1);
        chk("busy_pc_stable", pc, m_pc);

        // Reset during EXEC of M=D abandons the write.
        run_instr(16'h0010);
        instr_in    = 16'hE308;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("exec_rst_write", mem_write, 0);
        chk("exec_rst_a", mem_addr, 15'h0000);
        chk("exec_rst_d", alu_x, 16'h0000);
        chk("exec_rst_pc", pc, 15'h0000);
        chk("exec_rst_ready", instr_ready, 1);
        @(negedge clk);
        chk("exec_rst_write_after", mem_write, 0);
        chk("exec_rst_mem", mem_in, ref_mem[mem_addr]);

        // Random instruction stream against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic [15:0] ins;
            if ($urandom_range(0, 9) < 4) begin
                if ($urandom_range(0, 1) == 1) ins = 16'($urandom_range(0, 31));
                else ins = 16'($urandom & 32'h7FFF);
            end else begin
                ins = {3'b111, 1'($urandom), 6'($urandom), 3'($urandom), 3'($urandom)};
            end
            run_instr(ins);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
